// File: rtl/cache_flush_engine.sv
// Write-back flush walker for one cache way: scans every set, writes valid+dirty
// lines to pmem, clears their dirty bits, then pulses flush_done_o.
//
// state   | meaning
// IDLE    | waiting for flush_req_i, index held at 0
// SCAN    | inspecting the set at idx_q
// WRITE   | pmem write of the latched line in progress
// CLEAN   | one-cycle dirty-bit clear for the set at idx_q
// DONE    | one-cycle completion pulse
module cache_flush_engine #(
    parameter int width        = 128,
    parameter int index_width  = 3,
    parameter int tag_width    = 9,
    parameter int offset_width = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_req_i,
    output logic                   busy_o,
    output logic                   flush_done_o,
    output logic [index_width-1:0] arr_index_o,
    input  logic [width-1:0]       data_in_i,
    input  logic [tag_width-1:0]   tag_in_i,
    input  logic                   valid_in_i,
    input  logic                   dirty_in_i,
    output logic                   dirty_write_o,
    output logic                   dirty_datain_o,
    output logic                   pmem_write_o,
    output logic [15:0]            pmem_address_o,
    output logic [width-1:0]       pmem_wdata_o,
    input  logic                   pmem_resp_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_CLEAN,
        S_DONE
    } state_t;

    localparam logic [index_width-1:0] LAST_IDX = '1;

    state_t                 state_q;
    logic [index_width-1:0] idx_q;
    logic                   busy_q;
    logic                   flush_done_q;
    logic                   dirty_write_q;
    logic                   pmem_write_q;
    logic [15:0]            addr_q;
    logic [width-1:0]       wdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            flush_done_q  <= 1'b0;
            dirty_write_q <= 1'b0;
            pmem_write_q  <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            flush_done_q  <= 1'b0;
            dirty_write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush_req_i) begin
                        state_q <= S_SCAN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // A line needs writing only when both valid and dirty.
                    if (valid_in_i && dirty_in_i) begin
                        state_q      <= S_WRITE;
                        addr_q       <= {tag_in_i, idx_q, {offset_width{1'b0}}};
                        wdata_q      <= data_in_i;
                        pmem_write_q <= 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        state_q      <= S_DONE;
                        flush_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (pmem_resp_i) begin
                        state_q       <= S_CLEAN;
                        pmem_write_q  <= 1'b0;
                        dirty_write_q <= 1'b1;
                    end
                end
                S_CLEAN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q      <= S_DONE;
                        flush_done_q <= 1'b1;
                    end else begin
                        state_q <= S_SCAN;
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
                default: begin
                    state_q       <= S_IDLE;
                    busy_q        <= 1'b0;
                    idx_q         <= '0;
                    pmem_write_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign flush_done_o   = flush_done_q;
    assign arr_index_o    = idx_q;
    assign dirty_write_o  = dirty_write_q;
    assign dirty_datain_o = 1'b0;
    assign pmem_write_o   = pmem_write_q;
    assign pmem_address_o = addr_q;
    assign pmem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_cache_flush_engine.sv
// Bench for cache_flush_engine: behavioural array/memory model and a reference
// that predicts the write list and flush duration from the array contents.
module tb_cache_flush_engine;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         flush_req_i;
    logic         busy_o;
    logic         flush_done_o;
    logic [2:0]   arr_index_o;
    logic [127:0] data_in_i;
    logic [8:0]   tag_in_i;
    logic         valid_in_i;
    logic         dirty_in_i;
    logic         dirty_write_o;
    logic         dirty_datain_o;
    logic         pmem_write_o;
    logic [15:0]  pmem_address_o;
    logic [127:0] pmem_wdata_o;
    logic         pmem_resp_i;

    logic [127:0] mem_data [8];
    logic [8:0]   mem_tag  [8];
    logic         mem_valid[8];
    logic         mem_dirty[8];

    int total = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    assign data_in_i  = mem_data[arr_index_o];
    assign tag_in_i   = mem_tag[arr_index_o];
    assign valid_in_i = mem_valid[arr_index_o];
    assign dirty_in_i = mem_dirty[arr_index_o];

    cache_flush_engine dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .flush_req_i    (flush_req_i),
        .busy_o         (busy_o),
        .flush_done_o   (flush_done_o),
        .arr_index_o    (arr_index_o),
        .data_in_i      (data_in_i),
        .tag_in_i       (tag_in_i),
        .valid_in_i     (valid_in_i),
        .dirty_in_i     (dirty_in_i),
        .dirty_write_o  (dirty_write_o),
        .dirty_datain_o (dirty_datain_o),
        .pmem_write_o   (pmem_write_o),
        .pmem_address_o (pmem_address_o),
        .pmem_wdata_o   (pmem_wdata_o),
        .pmem_resp_i    (pmem_resp_i)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_arrays();
        for (int i = 0; i < 8; i++) begin
            mem_valid[i] = 1'b0;
            mem_dirty[i] = 1'b0;
            mem_tag[i]   = 9'($urandom);
            mem_data[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic set_line(input int i, input bit v, input bit d, input logic [8:0] t,
                            input logic [127:0] dat);
        mem_valid[i] = v;
        mem_dirty[i] = d;
        mem_tag[i]   = t;
        mem_data[i]  = dat;
    endtask

    // fixed_lat > 0 forces every write latency; 0 picks random latencies 1..4.
    task automatic run_flush(input string name, input int fixed_lat, input bit stray);
        logic [15:0]  exp_a[$];
        logic [127:0] exp_d[$];
        int           exp_i[$];
        int           lat[$];
        logic [15:0]  got_a[$];
        logic [127:0] got_d[$];
        int           got_i[$];
        int exp_busy, busy_cnt, done_cnt, done_cyc, wcyc, wk, cyc;
        bit unstable, bad_datain;
        logic [2:0] first_idx;

        exp_busy = 9;
        for (int i = 0; i < 8; i++) begin
            if (mem_valid[i] && mem_dirty[i]) begin
                exp_a.push_back({mem_tag[i], 3'(i), 4'b0000});
                exp_d.push_back(mem_data[i]);
                exp_i.push_back(i);
                lat.push_back(fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 4)));
                exp_busy += lat[$] + 1;
            end
        end

        busy_cnt = 0; done_cnt = 0; done_cyc = 0; wcyc = 0; wk = 0;
        unstable = 1'b0; bad_datain = 1'b0;

        @(negedge clk_i);
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        cyc = 1;
        first_idx = arr_index_o;
        while (busy_o === 1'b1 && cyc < 400) begin
            busy_cnt++;
            pmem_resp_i = 1'b0;
            flush_req_i = 1'b0;
            if (flush_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dirty_write_o) begin
                got_i.push_back(int'(arr_index_o));
                if (dirty_datain_o !== 1'b0) bad_datain = 1'b1;
            end
            if (pmem_write_o) begin
                if (wcyc == 0) begin
                    got_a.push_back(pmem_address_o);
                    got_d.push_back(pmem_wdata_o);
                end else if (pmem_address_o !== got_a[$] || pmem_wdata_o !== got_d[$]) begin
                    unstable = 1'b1;
                end
                wcyc++;
                if (wcyc >= (wk < lat.size() ? lat[wk] : 1)) begin
                    pmem_resp_i = 1'b1;
                    wk++;
                    wcyc = 0;
                end
            end else if (stray && !dirty_write_o && !flush_done_o) begin
                pmem_resp_i = ($urandom_range(0, 2) == 0);
            end
            if (stray && !flush_done_o)
                flush_req_i = ($urandom_range(0, 3) == 0);
            @(negedge clk_i);
            cyc++;
        end
        pmem_resp_i = 1'b0;
        flush_req_i = 1'b0;

        chk({name, " idle_at_end"}, busy_o, 1'b0);
        chk({name, " first_index"}, first_idx, 3'd0);
        chk({name, " busy_cycles"}, busy_cnt, exp_busy);
        chk({name, " done_pulses"}, done_cnt, 1);
        chk({name, " done_cycle"}, done_cyc, exp_busy);
        chk({name, " write_count"}, got_a.size(), exp_a.size());
        chk({name, " clean_count"}, got_i.size(), exp_i.size());
        chk({name, " wr_stable"}, unstable, 1'b0);
        chk({name, " datain_zero"}, bad_datain, 1'b0);
        for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
            chk({name, " wr_addr"}, got_a[k], exp_a[k]);
            chk({name, " wr_data"}, got_d[k], exp_d[k]);
        end
        for (int k = 0; k < exp_i.size() && k < got_i.size(); k++)
            chk({name, " clean_idx"}, got_i[k], exp_i[k]);
    endtask

    initial begin
        int waited;
        rst_n_i     = 1'b0;
        flush_req_i = 1'b0;
        pmem_resp_i = 1'b0;
        clear_arrays();
        repeat (3) @(negedge clk_i);
        chk("rst busy", busy_o, 1'b0);
        chk("rst done", flush_done_o, 1'b0);
        chk("rst index", arr_index_o, 3'd0);
        chk("rst dirty_write", dirty_write_o, 1'b0);
        chk("rst datain", dirty_datain_o, 1'b0);
        chk("rst pmem_write", pmem_write_o, 1'b0);
        chk("rst addr", pmem_address_o, 16'h0);
        chk("rst wdata", pmem_wdata_o, 128'h0);
        rst_n_i = 1'b1;

        clear_arrays();
        run_flush("all_clean", 1, 1'b0);

        clear_arrays();
        set_line(5, 1'b1, 1'b1, 9'h1A3, {16'hDEAD, 96'h0, 16'hBEEF});
        run_flush("set5", 3, 1'b0);

        clear_arrays();
        set_line(0, 1'b1, 1'b1, 9'h055, {$urandom, $urandom, $urandom, $urandom});
        set_line(7, 1'b1, 1'b1, 9'h1F0, {$urandom, $urandom, $urandom, $urandom});
        run_flush("sets0_7", 1, 1'b0);

        clear_arrays();
        set_line(2, 1'b0, 1'b1, 9'h0AA, {$urandom, $urandom, $urandom, $urandom});
        run_flush("invalid_dirty", 1, 1'b0);

        clear_arrays();
        set_line(1, 1'b1, 1'b1, 9'h101, {$urandom, $urandom, $urandom, $urandom});
        set_line(4, 1'b1, 1'b1, 9'h044, {$urandom, $urandom, $urandom, $urandom});
        run_flush("stray", 2, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++)
                set_line(i, 1'($urandom), 1'($urandom), 9'($urandom),
                         {$urandom, $urandom, $urandom, $urandom});
            run_flush("random", 0, r[0]);
        end

        clear_arrays();
        set_line(3, 1'b1, 1'b1, 9'h123, {$urandom, $urandom, $urandom, $urandom});
        @(negedge clk_i);
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        waited = 0;
        while (pmem_write_o !== 1'b1 && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        chk("rstwr reached_write", pmem_write_o, 1'b1);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        chk("rstwr busy", busy_o, 1'b0);
        chk("rstwr pmem_write", pmem_write_o, 1'b0);
        chk("rstwr addr", pmem_address_o, 16'h0);
        chk("rstwr wdata", pmem_wdata_o, 128'h0);
        chk("rstwr index", arr_index_o, 3'd0);
        chk("rstwr done", flush_done_o, 1'b0);
        chk("rstwr dirty_write", dirty_write_o, 1'b0);
        rst_n_i = 1'b1;
        run_flush("after_rst", 2, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
